mul16_seq_ctrl: RTL and testbench

- Sequenced 16x16 unsigned multiplier built around one shared 8x8 Wallace-tree multiplier instance (walmult8x8, combinational, 16-bit product).
- Controller accepts an operand pair over a valid/ready handshake.
- Steps the four 8x8 half-products through the shared multiplier, one per cycle, and accumulates them into a 32-bit result.
- Presents the result on a valid/ready output. Used wherever a 16-bit product is needed and area matters more than throughput.

---
 rtl/mul16_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mul16_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl.sv
// Sequenced 16x16 unsigned multiplier: four 8x8 half-products run through one
// shared Wallace-tree 8x8 multiplier and accumulate into a 32-bit result.

module walmult8x8 (
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_y,
    output logic [15:0] o_p_c
);
    localparam int unsigned PW = 16;

    logic [PW-1:0] w_pp [8];
    logic [PW-1:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
    logic [PW-1:0] w_s4, w_c4, w_s5, w_c5;

    // 3:2 carry-save compressor over a whole row; returns {carry, sum}
    function automatic logic [2*PW-1:0] f_csa(input logic [PW-1:0] x,
                                              input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        s = x ^ y ^ z;
        c = PW'(((x & y) | (x & z) | (y & z)) << 1);
        return {c, s};
    endfunction

    for (genvar g = 0; g < 8; g++) begin : g_pp
        assign w_pp[g] = PW'({8{i_y[g]}} & i_x) << g;
    end

    // Reduction tree: 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
    // Row sums are modulo 2^16, which is exact since the product fits in 16 bits.
    assign {w_c0, w_s0} = f_csa(w_pp[0], w_pp[1], w_pp[2]);
    assign {w_c1, w_s1} = f_csa(w_pp[3], w_pp[4], w_pp[5]);
    assign {w_c2, w_s2} = f_csa(w_s0, w_c0, w_s1);
    assign {w_c3, w_s3} = f_csa(w_c1, w_pp[6], w_pp[7]);
    assign {w_c4, w_s4} = f_csa(w_s2, w_c2, w_s3);
    assign {w_c5, w_s5} = f_csa(w_s4, w_c4, w_c3);
    assign o_p_c = w_s5 + w_c5;
endmodule

module mul16_seq_ctrl #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic        busy
);
    localparam int unsigned OW = 16;
    localparam int unsigned HW = 8;
    localparam int unsigned ZW = 32;
    localparam int unsigned NSTEP = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [OW-1:0]     r_a, r_b, w_a_nxt, w_b_nxt;
    logic [ZW-1:0]     r_acc, w_acc_nxt, w_acc_sum;
    logic [ZW-1:0]     r_z, w_z_nxt;
    logic [NSTEP-1:0]  r_mask, w_mask_nxt, w_step_oh;
    logic              r_out_valid, w_out_valid_nxt;
    logic              r_in_ready, w_in_ready_nxt;
    logic              r_busy, w_busy_nxt;
    logic [1:0]        w_step;
    logic              w_has_step;
    logic [HW-1:0]     w_mul_x, w_mul_y;
    logic [2*HW-1:0]   w_prod;
    logic [ZW-1:0]     w_term;

    // Steps that contribute: bit k set when both selected halves are non-zero
    function automatic logic [NSTEP-1:0] f_mask(input logic [OW-1:0] x,
                                                input logic [OW-1:0] y);
        logic xl, xh, yl, yh;
        xl = (x[HW-1:0] != '0);
        xh = (x[OW-1:HW] != '0);
        yl = (y[HW-1:0] != '0);
        yh = (y[OW-1:HW] != '0);
        return {xh && yh, xh && yl, xl && yh, xl && yl};
    endfunction

    // Lowest pending step and the operand halves/shift it selects
    always_comb begin
        w_step = 2'd3;
        if (r_mask[0])      w_step = 2'd0;
        else if (r_mask[1]) w_step = 2'd1;
        else if (r_mask[2]) w_step = 2'd2;
        w_has_step = (r_mask != '0);
        w_step_oh  = w_has_step ? (NSTEP'(1) << w_step) : '0;
        w_mul_x    = w_step[1] ? r_a[OW-1:HW] : r_a[HW-1:0];
        w_mul_y    = w_step[0] ? r_b[OW-1:HW] : r_b[HW-1:0];
    end

    walmult8x8 u_mult (
        .i_x   (w_mul_x),
        .i_y   (w_mul_y),
        .o_p_c (w_prod)
    );

    always_comb begin
        w_term = ZW'(w_prod);
        unique case (w_step)
            2'd0:       w_term = ZW'(w_prod);
            2'd1, 2'd2: w_term = ZW'(w_prod) << 8;
            2'd3:       w_term = ZW'(w_prod) << 16;
            default:    w_term = ZW'(w_prod);
        endcase
        w_acc_sum = w_has_step ? (r_acc + w_term) : r_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_z         <= '0;
            r_mask      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_acc       <= w_acc_nxt;
            r_z         <= w_z_nxt;
            r_mask      <= w_mask_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_acc_nxt       = r_acc;
        w_z_nxt         = r_z;
        w_mask_nxt      = r_mask;
        w_out_valid_nxt = r_out_valid;

        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_acc_nxt   = '0;
                    w_mask_nxt  = EARLY_OUT ? f_mask(a, b) : '1;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                // An empty mask still spends this one cycle and adds nothing
                w_acc_nxt  = w_acc_sum;
                w_mask_nxt = r_mask & ~w_step_oh;
                if (w_mask_nxt == '0) begin
                    w_z_nxt         = w_acc_sum;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign z         = r_z;
    assign busy      = r_busy;
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Bench for mul16_seq_ctrl: instance 0 with EARLY_OUT=0, instance 1 with EARLY_OUT=1,
// checked every cycle against a transaction-level model plus directed literals.

module tb_mul16_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] op_a      [2];
    logic [15:0] op_b      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] z         [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 computing, 2 result held
    int          m_phase [2];
    int          m_cnt   [2];
    logic [31:0] m_res   [2];
    logic [31:0] m_z     [2];

    always #5 clk = ~clk;

    mul16_seq_ctrl #(.EARLY_OUT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(op_a[0]), .b(op_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .z(z[0]), .busy(busy[0])
    );

    mul16_seq_ctrl #(.EARLY_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(op_a[1]), .b(op_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .z(z[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got 0x%08h expected 0x%08h", name, inst, $time, act, exp);
        end
    endtask

    // Cycles from accept to result: one per contributing half-product, min 1
    function automatic int exp_lat(input bit eo, input logic [15:0] x, input logic [15:0] y);
        int n;
        if (!eo) return 4;
        n = 0;
        if (x[7:0] != 0 && y[7:0] != 0)   n++;
        if (x[7:0] != 0 && y[15:8] != 0)  n++;
        if (x[15:8] != 0 && y[7:0] != 0)  n++;
        if (x[15:8] != 0 && y[15:8] != 0) n++;
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 4))
            0: v = 16'h0000;
            1: v[15:8] = 8'h00;
            2: v[7:0] = 8'h00;
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0;
                m_cnt[i]   = 0;
                m_res[i]   = '0;
                m_z[i]     = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_phase[i])
                    0: if (in_valid[i]) begin
                        m_res[i]   = 32'(op_a[i]) * 32'(op_b[i]);
                        m_cnt[i]   = exp_lat(i == 1, op_a[i], op_b[i]);
                        m_phase[i] = 1;
                    end
                    1: begin
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) begin
                            m_z[i]     = m_res[i];
                            m_phase[i] = 2;
                        end
                    end
                    default: if (out_ready[i]) m_phase[i] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("out_valid", i, 32'(out_valid[i]), 32'(m_phase[i] == 2));
            chk("in_ready",  i, 32'(in_ready[i]),  32'(m_phase[i] == 0));
            chk("busy",      i, 32'(busy[i]),      32'(m_phase[i] != 0));
            chk("z",         i, z[i], m_z[i]);
        end
    end

    // One transaction with literal latency/result; optional backpressure and chaining
    task automatic run_op(input int i, input logic [15:0] x, input logic [15:0] y,
                          input int lat_exp, input logic [31:0] z_exp, input int hold,
                          input bit chain, input logic [15:0] cx, input logic [15:0] cy);
        int lat;
        int k;
        k = 0;
        while (!in_ready[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wait_ready", i, 32'(in_ready[i]), 32'd1);
        in_valid[i]  = 1'b1;
        op_a[i]      = x;
        op_b[i]      = y;
        out_ready[i] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid[i]) break;
        end
        chk("latency", i, 32'(lat), 32'(lat_exp));
        chk("z_literal", i, z[i], z_exp);
        chk("model_literal", i, m_z[i], z_exp);
        for (int n = 0; n < hold; n++) begin
            in_valid[i] = 1'($urandom_range(0, 1));
            op_a[i]     = 16'($urandom);
            op_b[i]     = 16'($urandom);
            @(negedge clk);
            chk("bp_valid", i, 32'(out_valid[i]), 32'd1);
            chk("bp_z",     i, z[i], z_exp);
            chk("bp_ready", i, 32'(in_ready[i]), 32'd0);
        end
        in_valid[i] = chain;
        if (chain) begin
            op_a[i] = cx;
            op_b[i] = cy;
        end
        out_ready[i] = 1'b1;
        chk("hs_z", i, z[i], z_exp);
        @(negedge clk);
        chk("hs_valid", i, 32'(out_valid[i]), 32'd0);
        chk("hs_ready", i, 32'(in_ready[i]), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            op_a[i]      = '0;
            op_b[i]      = '0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(in_ready[i]), 32'd1);
            chk("rst_busy",  i, 32'(busy[i]), 32'd0);
            chk("rst_valid", i, 32'(out_valid[i]), 32'd0);
            chk("rst_z",     i, z[i], 32'd0);
        end

        run_op(0, 16'h1234, 16'h5678, 4, 32'h06260060, 0, 1'b0, 16'h0, 16'h0);
        run_op(0, 16'hFFFF, 16'hFFFF, 4, 32'hFFFE0001, 0, 1'b0, 16'h0, 16'h0);

        // Asynchronous reset in the middle of a multiply
        in_valid[0] = 1'b1;
        op_a[0]     = 16'h1234;
        op_b[0]     = 16'h5678;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("mid_rst_busy",  0, 32'(busy[0]), 32'd0);
        chk("mid_rst_ready", 0, 32'(in_ready[0]), 32'd1);
        chk("mid_rst_z",     0, z[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("post_rst_valid", 0, 32'(out_valid[0]), 32'd0);
        end

        run_op(0, 16'h0000, 16'hFFFF, 4, 32'h00000000, 0, 1'b0, 16'h0, 16'h0);
        run_op(1, 16'h00FF, 16'h0003, 1, 32'h000002FD, 0, 1'b0, 16'h0, 16'h0);
        run_op(1, 16'h0100, 16'h0100, 1, 32'h00010000, 0, 1'b0, 16'h0, 16'h0);
        run_op(1, 16'h0000, 16'h1234, 1, 32'h00000000, 0, 1'b0, 16'h0, 16'h0);
        run_op(1, 16'h1234, 16'h5678, 4, 32'h06260060, 0, 1'b0, 16'h0, 16'h0);
        run_op(1, 16'h1200, 16'h0034, 1, 32'h0003A800, 0, 1'b0, 16'h0, 16'h0);

        // Backpressure, then back-to-back accept right after the handshake
        run_op(0, 16'h1234, 16'h5678, 4, 32'h06260060, 5, 1'b1, 16'h0003, 16'h0005);
        run_op(0, 16'h0003, 16'h0005, 4, 32'h0000000F, 0, 1'b0, 16'h0, 16'h0);
        run_op(1, 16'h1234, 16'h5678, 4, 32'h06260060, 5, 1'b1, 16'h0003, 16'h0005);
        run_op(1, 16'h0003, 16'h0005, 1, 32'h0000000F, 0, 1'b0, 16'h0, 16'h0);

        // Random traffic on both instances, checked cycle by cycle
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = ($urandom_range(0, 2) != 0);
                op_a[i]      = rnd16();
                op_b[i]      = rnd16();
                out_ready[i] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
